riscv_encoder: RTL
==================

# riscv_encoder

Streaming RV32I instruction encoder, the inverse of the core's instruction decoder: accepts decoded fields (format, opcode, registers, functs, 32-bit signed immediate) over a valid/ready handshake, scrambles the immediate into the bit positions its format requires, and emits 32-bit instruction words tagged with sequential instruction-memory word addresses. It sits between the debug/boot-loader front end and the instruction-memory write port. Illegal formats and out-of-range immediates are dropped and counted.

## Interface
- `ADDR_W`, 32: width of `out_addr`.
- `BASE_ADDR`, 0: byte address of the first emitted word; must be 4-aligned.
- `DEPTH_WORDS`, 1024: words in the target memory region; address wrap point.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `clr` in 1: synchronous flush and counter clear.
- `in_valid` in 1 / `in_ready` out 1: request handshake.
- `in_fmt` in 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6–7 are illegal.
- `in_opcode` in 7; `in_rd`, `in_rs1`, `in_rs2` in 5; `in_funct3` in 3; `in_funct7` in 7.
- `in_imm` in 32: signed byte-offset or value immediate, unscrambled.
- `out_valid` out 1 / `out_ready` in 1: word handshake.
- `out_data` out 32: encoded instruction.
- `out_addr` out ADDR_W: byte address of `out_data`.
- `err_sticky` out 1: set on any dropped request.
- `err_count` out 8: dropped requests, saturating at 255.

## Operation
- Two stages: S1 input register, S2 output register. Transfer happens when valid && ready in the same cycle.
- `in_ready = !s1_valid || s1_moves`. S1 moves when S2 is empty, when `out_ready` is high, or when the S1 entry is an error (dropped without using S2). There is a combinational path from `out_ready` to `in_ready`.
- Packing (opcode always in [6:0]):
  - R: {funct7, rs2, rs1, funct3, rd, op}.
  - I: {imm[11:0], rs1, funct3, rd, op}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Range checks, all compiled in by the macro:
  - I and S: imm[31:11] all equal.
  - B: imm[31:12] all equal, and imm[0] = 0.
  - J: imm[31:20] all equal, and imm[0] = 0.
  - U: imm[11:0] = 0.
  - R: never errors.
  - fmt 6–7: always an error.
- Errored entry:
  - Discarded when leaving S1.
  - `err_sticky` is set and `err_count` increments (saturating).
  - The address counter does not advance.
- Address counter `next_addr`:
  - Captured into `out_addr` when S2 loads, then advances by 4.
  - Wraps from BASE_ADDR+4*(DEPTH_WORDS−1) back to BASE_ADDR.
- `clr`:
  - Invalidates S1 and S2, sets `next_addr` to BASE_ADDR, and zeroes `err_sticky` and `err_count`.
  - `in_ready` is forced low during the `clr` cycle.
  - `clr` wins over any simultaneous load, error, or transfer.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_addr`=BASE_ADDR, `err_sticky`=0, `err_count`=0. `in_ready`=1 after reset, since S1 is empty.
- Latency: a request accepted at edge N makes `out_valid` high after edge N+1, when S2 is free.
- Throughput: 1 word/cycle with `out_ready` held high.
- With `out_ready` low, at most 2 requests are held (S1+S2), then `in_ready` drops.
- `out_data` and `out_addr` stay stable while `out_valid && !out_ready`.
- Reset assertion mid-stream discards all held entries immediately.

## Configuration
- `RISCV_ENC_RANGE_CHECK_EN` defined: range and format checks active; errors are dropped and counted as above.
- Not defined:
  - No checks. Immediates are silently truncated to their format's field bits.
  - fmt 6–7 pack as R.
  - `err_sticky` and `err_count` are tied to 0.

## Structure
- Package `riscv_enc_pkg`: format-code constants (FMT_R…FMT_J), base opcode constants (OP_LUI 0x37, OP_JAL 0x6F, OP_BRANCH 0x63, OP_STORE 0x23, OP_IMM 0x13, …).
- Sub-module `riscv_imm_pack`: combinational field packing plus range check; outputs `word[31:0]` and `err`. Instantiated at S1's output.

## Test plan
- I fmt, op 0x13, rd=1, rs1=0, f3=0, imm=5 (ADDI x1,x0,5) -> `out_data`=0x00500093, `out_addr`=BASE_ADDR.
- S fmt, op 0x23, f3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423. B fmt, op 0x63, imm=−4, regs 0 -> 0xFE000EE3.
- J fmt, op 0x6F, rd=1, imm=0x800 -> 0x001000EF. U fmt, op 0x37, rd=5, imm=0x12345000 -> 0x123452B7.
- I fmt with imm=2048, then a valid request:
  - With the macro: first request dropped, `err_sticky`=1, `err_count`=1, second word at BASE_ADDR.
  - Without the macro: word 0x80000093-style truncation emitted.
- `out_ready`=0 and 3 back-to-back requests -> 2 accepted, `in_ready` low; release `out_ready` -> words in order at BASE, +4, +8.
- DEPTH_WORDS=4, 5 requests -> 5th `out_addr`=BASE_ADDR. Then `clr` with S2 full -> `out_valid`=0 next cycle, `err_count`=0.

Source files
------------

// File: rtl/riscv_enc_pkg.sv
// Shared constants, request record and immediate-range helper for the RV32I encoder.
package riscv_enc_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_req_t;

    // True when imm[31:lsb] is a pure sign extension (all ones or all zeros).
    function automatic logic upper_uniform(input logic [31:0] imm, input int unsigned lsb);
        logic [31:0] mask_s;
        mask_s = 32'hFFFF_FFFF << lsb;
        return ((imm & mask_s) == mask_s) || ((imm & mask_s) == 32'h0000_0000);
    endfunction

endpackage

// File: rtl/riscv_imm_pack.sv
// Combinational RV32I field packer with immediate range check.
// Checks are present only when RISCV_ENC_RANGE_CHECK_EN is defined.
module riscv_imm_pack
    import riscv_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err
);

    // Scramble the immediate into the bit positions of the selected format.
    always_comb begin
        word = {funct7, rs2, rs1, funct3, rd, opcode};
        case (fmt)
            FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:   word = {imm[31:12], rd, opcode};
            FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word = {funct7, rs2, rs1, funct3, rd, opcode};
        endcase
    end

`ifdef RISCV_ENC_RANGE_CHECK_EN
    // Flag immediates that do not fit their field, and unknown formats.
    always_comb begin
        err = 1'b0;
        case (fmt)
            FMT_R:        err = 1'b0;
            FMT_I, FMT_S: err = !upper_uniform(imm, 32'd11);
            FMT_B:        err = !upper_uniform(imm, 32'd12) || imm[0];
            FMT_J:        err = !upper_uniform(imm, 32'd20) || imm[0];
            FMT_U:        err = (imm[11:0] != 12'h000);
            default:      err = 1'b1;
        endcase
    end
`else
    assign err = 1'b0;
    logic unused_imm_s;
    assign unused_imm_s = imm[0];
`endif

endmodule

// File: rtl/riscv_encoder.sv
// Two-stage streaming RV32I encoder: S1 input register, S2 output register with address tag.
// Optional range/format checking and error counting via RISCV_ENC_RANGE_CHECK_EN.
module riscv_encoder
    import riscv_enc_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = {ADDR_W{1'b0}},
    parameter int                DEPTH_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_sticky,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'((DEPTH_WORDS - 32'sd1) * 32'sd4);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(32'd4);

    logic              s1_valid_r;
    enc_req_t          s1_req_r;
    logic [ADDR_W-1:0] next_addr_r;
    logic [31:0]       pack_word_s;
    logic              pack_err_s;
    logic              s2_free_s;
    logic              s1_moves_s;
    logic              s2_load_s;
    logic              in_fire_s;

    riscv_imm_pack u_pack (
        .fmt    (s1_req_r.fmt),
        .opcode (s1_req_r.opcode),
        .rd     (s1_req_r.rd),
        .rs1    (s1_req_r.rs1),
        .rs2    (s1_req_r.rs2),
        .funct3 (s1_req_r.funct3),
        .funct7 (s1_req_r.funct7),
        .imm    (s1_req_r.imm),
        .word   (pack_word_s),
        .err    (pack_err_s)
    );

    // An errored S1 entry leaves without needing S2, so it never stalls on backpressure.
    assign s2_free_s  = !out_valid || out_ready;
    assign s1_moves_s = s1_valid_r && (s2_free_s || pack_err_s);
    assign s2_load_s  = s1_valid_r && !pack_err_s && s2_free_s;
    assign in_ready   = !clr && (!s1_valid_r || s1_moves_s);
    assign in_fire_s  = in_valid && in_ready;

    // S1 input register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_req_r   <= {$bits(enc_req_t){1'b0}};
        end else if (clr) begin
            s1_valid_r <= 1'b0;
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            s1_req_r   <= '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                            funct3: in_funct3, funct7: in_funct7, imm: in_imm};
        end else if (s1_moves_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // S2 output register and wrapping word-address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= 32'h0000_0000;
            out_addr    <= BASE_ADDR;
            next_addr_r <= BASE_ADDR;
        end else if (clr) begin
            out_valid   <= 1'b0;
            next_addr_r <= BASE_ADDR;
        end else if (s2_load_s) begin
            out_valid   <= 1'b1;
            out_data    <= pack_word_s;
            out_addr    <= next_addr_r;
            next_addr_r <= (next_addr_r == LAST_ADDR) ? BASE_ADDR : next_addr_r + ADDR_STEP;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

`ifdef RISCV_ENC_RANGE_CHECK_EN
    // Sticky error flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            err_count  <= 8'h00;
        end else if (clr) begin
            err_sticky <= 1'b0;
            err_count  <= 8'h00;
        end else if (s1_valid_r && pack_err_s) begin
            err_sticky <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'h01;
            end
        end
    end
`else
    assign err_sticky = 1'b0;
    assign err_count  = 8'h00;
`endif

endmodule
